// File: rtl/lock_pkg.sv
// lock_pkg: shared digit constants and sequencer states for the lock code sender.
package lock_pkg;
   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
   typedef enum logic [2:0] {IDLE, SEND, GAP, CHECK, FIN} state_t;
endpackage

// File: rtl/lock_gap_timer.sv
// lock_gap_timer: loadable down-counter flagging the end of an inter-digit gap.
module lock_gap_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       dec,
   input  logic [3:0] load_val,
   output logic       expired
);
   logic [3:0] cnt_q, cnt_d;
   always_comb cnt_d = load ? load_val : (dec && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= 4'd0;
      else cnt_q <= cnt_d;
   assign expired = cnt_q == 4'd0;
endmodule

// File: rtl/lock_code_sender.sv
// lock_code_sender: strobes a BCD code into a lock digit by digit and reports the lock's verdict.
module lock_code_sender
   import lock_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int GAP_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] code,
   input  logic                          lock_open,
   input  logic                          lock_closed,
   output logic [3:0]                    digit,
   output logic                          digit_valid,
   output logic                          busy,
   output logic                          done,
   output logic                          pass,
   output logic                          err
);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
   state_t state_q, state_d;
   logic [DIGIT_W*NUM_DIGITS-1:0] code_q, code_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [3:0] digit_q, digit_d;
   logic bad_q, bad_d, ok_q, ok_d, digit_valid_q, digit_valid_d;
   logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, err_q, err_d;
   logic bad_in, strobe, fin, accept, expired;
   lock_gap_timer u_gap (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state_q == SEND),
      .dec      (state_q == GAP),
      .load_val (GAP_LOAD),
      .expired  (expired)
   );
   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) bad_in = bad_in | (code[DIGIT_W*i +: DIGIT_W] > MAX_DIGIT);
      accept = state_q == IDLE && start;
      strobe = state_q == SEND && !bad_q && !abort;
      fin = state_q == FIN && !abort;
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? SEND : IDLE;
         SEND:    state_d = bad_q ? FIN : GAP;
         GAP:     state_d = !expired ? GAP : idx_q == LAST ? CHECK : SEND;
         CHECK:   state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && state_q != IDLE) state_d = IDLE;
      code_d = accept ? code : strobe ? code_q << DIGIT_W : code_q;
      idx_d = state_q == IDLE ? '0 : (state_q == GAP && expired && idx_q != LAST) ? idx_q + 1'b1 : idx_q;
      bad_d = accept ? bad_in : bad_q;
      ok_d = state_q == CHECK ? lock_open & ~lock_closed : ok_q;
      digit_d = strobe ? code_q[DIGIT_W*NUM_DIGITS-1 -: DIGIT_W] : digit_q;
      digit_valid_d = strobe;
      busy_d = state_q != IDLE && !abort;
      done_d = fin;
      pass_d = fin ? ok_q & ~bad_q : pass_q;
      err_d = fin ? bad_q : err_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q       <= IDLE;
         code_q        <= '0;
         idx_q         <= '0;
         bad_q         <= 1'b0;
         ok_q          <= 1'b0;
         digit_q       <= 4'd0;
         digit_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         code_q        <= code_d;
         idx_q         <= idx_d;
         bad_q         <= bad_d;
         ok_q          <= ok_d;
         digit_q       <= digit_d;
         digit_valid_q <= digit_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         err_q         <= err_d;
      end
   assign digit = digit_q;
   assign digit_valid = digit_valid_q;
   assign busy = busy_q;
   assign done = done_q;
   assign pass = pass_q;
   assign err = err_q;
endmodule
